// File: rtl/loa_pkg.sv
// ----------------------------------------------------------------------------
// loa_pkg : shared constants and helpers for the Lower-part OR Adder (LOA).
//   LOA_N_DEF     default operand / sum width
//   LOA_K_DEF     default number of approximate low-order bits
//   loa_ref_width width of an exact unsigned sum of two n-bit operands (n+1)
// ----------------------------------------------------------------------------
package loa_pkg;

    localparam int LOA_N_DEF = 4;
    localparam int LOA_K_DEF = 2;

    function automatic int loa_ref_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/loa_if.sv
// ----------------------------------------------------------------------------
// loa_if : operand / result bundle for loa_adder.
//   i_Valid, i_A, i_B       operands (driven by master)
//   o_Valid, o_Sum, o_Cout  registered result (driven by slave)
//   o_ErrDist               |exact - approx|, present only with LOA_ERRDIST_EN
// Modports: master (operand source / result sink), slave (the adder).
// ----------------------------------------------------------------------------
interface loa_if #(
    parameter int N = loa_pkg::LOA_N_DEF
);
    logic         i_Valid;
    logic [N-1:0] i_A;
    logic [N-1:0] i_B;
    logic         o_Valid;
    logic [N-1:0] o_Sum;
    logic         o_Cout;
`ifdef LOA_ERRDIST_EN
    logic [N:0]   o_ErrDist;
`endif

    modport master (
        output i_Valid, i_A, i_B,
`ifdef LOA_ERRDIST_EN
        input  o_ErrDist,
`endif
        input  o_Valid, o_Sum, o_Cout
    );

    modport slave (
        input  i_Valid, i_A, i_B,
`ifdef LOA_ERRDIST_EN
        output o_ErrDist,
`endif
        output o_Valid, o_Sum, o_Cout
    );
endinterface

// File: rtl/loa_full_adder.sv
// ----------------------------------------------------------------------------
// loa_full_adder : 1-bit full adder, one cell of the exact upper ripple chain.
//   i_A, i_B, i_Cin -> o_S (sum), o_Cout (carry)
// ----------------------------------------------------------------------------
module loa_full_adder (
    input  logic i_A,
    input  logic i_B,
    input  logic i_Cin,
    output logic o_S,
    output logic o_Cout
);
    assign o_S    = i_A ^ i_B ^ i_Cin;
    assign o_Cout = (i_A & i_B) | (i_Cin & (i_A ^ i_B));
endmodule

// File: rtl/loa_adder.sv
// ----------------------------------------------------------------------------
// loa_adder : N-bit Lower-part OR Adder with a one-cycle registered result.
//   Bits [K-1:0] are A|B; bits [N-1:K] are an exact ripple add whose carry-in
//   is A[K-1]&B[K-1]. Result {o_Cout,o_Sum} is registered on i_Valid.
// Ports:
//   i_Clk    rising-edge clock
//   i_Rst_n  synchronous active-low reset (clears o_Valid/o_Sum/o_Cout)
//   io_Bus   loa_if.slave: i_Valid/i_A/i_B in, o_Valid/o_Sum/o_Cout out
// Optional: define LOA_ERRDIST_EN to add io_Bus.o_ErrDist = |(A+B) - result|.
// ----------------------------------------------------------------------------
module loa_adder
    import loa_pkg::*;
#(
    parameter int N = LOA_N_DEF,
    parameter int K = LOA_K_DEF
) (
    input  logic  i_Clk,
    input  logic  i_Rst_n,
    loa_if.slave  io_Bus
);
    if (N < 1 || K < 0 || K > N) begin : g_bad_param
        $error("loa_adder: need N >= 1 and 0 <= K <= N");
    end

    logic [N-1:0] w_Sum;
    logic [N-K:0] w_Carry;   // w_Carry[0] is the injected carry, [N-K] is cout

    // Lower OR lane and injected carry; with K=0 the adder is fully exact.
    if (K == 0) begin : g_no_lower
        assign w_Carry[0] = 1'b0;
    end else begin : g_lower
        assign w_Sum[K-1:0] = io_Bus.i_A[K-1:0] | io_Bus.i_B[K-1:0];
        assign w_Carry[0]   = io_Bus.i_A[K-1] & io_Bus.i_B[K-1];
    end

    // Exact upper ripple chain; empty when K=N, leaving cout = injected carry.
    for (genvar i = 0; i < N - K; i++) begin : g_fa
        loa_full_adder u_fa (
            .i_A    (io_Bus.i_A[K+i]),
            .i_B    (io_Bus.i_B[K+i]),
            .i_Cin  (w_Carry[i]),
            .o_S    (w_Sum[K+i]),
            .o_Cout (w_Carry[i+1])
        );
    end

    logic         r_Valid;
    logic [N-1:0] r_Sum;
    logic         r_Cout;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_Valid <= 1'b0;
            r_Sum   <= '0;
            r_Cout  <= 1'b0;
        end else begin
            r_Valid <= io_Bus.i_Valid;
            if (io_Bus.i_Valid) begin
                r_Sum  <= w_Sum;
                r_Cout <= w_Carry[N-K];
            end
        end
    end

    assign io_Bus.o_Valid = r_Valid;
    assign io_Bus.o_Sum   = r_Sum;
    assign io_Bus.o_Cout  = r_Cout;

`ifdef LOA_ERRDIST_EN
    logic [N:0] w_Exact;
    logic [N:0] w_Approx;
    logic [N:0] w_ErrDist;
    logic [N:0] r_ErrDist;

    assign w_Exact   = {1'b0, io_Bus.i_A} + {1'b0, io_Bus.i_B};
    assign w_Approx  = {w_Carry[N-K], w_Sum};
    // Approximation can land on either side of the exact sum (the injected
    // carry overshoots, the OR lane undershoots), so take the magnitude.
    assign w_ErrDist = (w_Approx >= w_Exact) ? (w_Approx - w_Exact)
                                             : (w_Exact - w_Approx);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_ErrDist <= '0;
        end else if (io_Bus.i_Valid) begin
            r_ErrDist <= w_ErrDist;
        end
    end

    assign io_Bus.o_ErrDist = r_ErrDist;
`endif

endmodule

// File: tb/tb_loa_adder.sv
// ----------------------------------------------------------------------------
// tb_loa_adder : self-checking bench for loa_adder (N=4, K=2).
// Directed cases, hold behaviour, exhaustive back-to-back sweep, randomized
// valid/operand traffic and a mid-stream reset, all against an arithmetic
// model of the LOA rules.
// ----------------------------------------------------------------------------
module tb_loa_adder;
    import loa_pkg::*;

    localparam int N = 4;
    localparam int K = 2;
    localparam int W = loa_ref_width(N);

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    loa_if #(.N(N)) bus ();

    loa_adder #(.N(N), .K(K)) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .io_Bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // LOA result from the rules: OR the low K bits, add the upper fields
    // arithmetically with the injected carry, then splice.
    function automatic logic [W-1:0] loa_model(input int a, input int b);
        int lo, cin, up;
        lo  = (a | b) & ((1 << K) - 1);
        cin = (K == 0) ? 0 : ((a >> (K - 1)) & (b >> (K - 1)) & 1);
        up  = (a >> K) + (b >> K) + cin;
        return W'((up << K) | lo);
    endfunction

    function automatic int err_model(input int a, input int b);
        int d;
        d = int'(loa_model(a, b)) - (a + b);
        return (d < 0) ? -d : d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input int b);
        bus.i_Valid = v;
        bus.i_A     = N'(a);
        bus.i_B     = N'(b);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] res, input int ed);
        chk({tag, ".valid"}, 32'(bus.o_Valid), 32'(v));
        chk({tag, ".sum"},   32'(bus.o_Sum),   32'(res[N-1:0]));
        chk({tag, ".cout"},  32'(bus.o_Cout),  32'(res[N]));
`ifdef LOA_ERRDIST_EN
        chk({tag, ".errdist"}, 32'(bus.o_ErrDist), 32'(ed));
        chk({tag, ".errbound"}, 32'(bus.o_ErrDist <= (W)'(1 << K)), 32'd1);
`else
        if (ed < 0) $display("note: negative error distance");
`endif
    endtask

    typedef struct { int a; int b; logic [W-1:0] res; int ed; } dir_t;

    initial begin
        dir_t          dirs[4];
        logic [W-1:0]  hold_res;
        int            hold_ed;
        logic          exp_v;
        logic [W-1:0]  exp_res;
        int            exp_ed;
        int            a, b;
        logic          v;

        n_vec = 0;
        n_err = 0;

        // Reset held for 2 cycles with valid operands present.
        rst_n = 1'b0;
        drive(1'b1, 15, 15);
        tick();
        tick();
        check_out("reset", 1'b0, '0, 0);

        // Directed cases: expected values taken straight from the LOA rules.
        dirs[0] = '{a: 5,  b: 10, res: 5'b01111, ed: 0};
        dirs[1] = '{a: 3,  b: 1,  res: 5'b00011, ed: 1};
        dirs[2] = '{a: 2,  b: 2,  res: 5'b00110, ed: 2};
        dirs[3] = '{a: 15, b: 15, res: 5'b11111, ed: 1};
        rst_n = 1'b1;
        foreach (dirs[i]) begin
            drive(1'b1, dirs[i].a, dirs[i].b);
            tick();
            check_out($sformatf("dir%0d", i), 1'b1, dirs[i].res, dirs[i].ed);
        end

        // Idle: outputs hold while operands wander.
        hold_res = dirs[3].res;
        hold_ed  = dirs[3].ed;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
            check_out($sformatf("hold%0d", i), 1'b0, hold_res, hold_ed);
        end

        // Exhaustive sweep, one operand pair per cycle.
        for (int p = 0; p < 256; p++) begin
            drive(1'b1, p >> 4, p & 15);
            tick();
            check_out($sformatf("sweep%0d", p), 1'b1, loa_model(p >> 4, p & 15),
                      err_model(p >> 4, p & 15));
        end
        exp_res = loa_model(15, 15);
        exp_ed  = err_model(15, 15);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            drive(v, a, b);
            tick();
            exp_v = v;
            if (v) begin
                exp_res = loa_model(a, b);
                exp_ed  = err_model(a, b);
            end
            check_out($sformatf("rand%0d", i), exp_v, exp_res, exp_ed);
        end

        // Reset with an operation in flight discards it.
        drive(1'b1, 9, 7);
        rst_n = 1'b0;
        tick();
        check_out("midreset", 1'b0, '0, 0);
        rst_n = 1'b1;
        drive(1'b1, 9, 7);
        tick();
        check_out("postreset", 1'b1, loa_model(9, 7), err_model(9, 7));

        drive(1'b0, 0, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/loa_adder.md
Name: loa_adder

Overview:
- Parameterised N-bit Lower-part OR Adder (LOA): an approximate adder for error-tolerant datapaths.
- The K least-significant bits are approximated with bitwise OR.
- The upper N-K bits use an exact ripple-carry adder. Its carry-in is the AND of the two operand bits at position K-1.
- Result is registered; one-cycle latency with a valid flag.

Parameters:
- N, 4, operand and sum width in bits; N >= 1.
- K, 2, number of approximate low-order bits; 0 <= K <= N. Out-of-range values are an elaboration error.

Ports:
- i_Clk  input  1  system clock; all logic samples on rising edge.
- i_Rst_n  input  1  reset, synchronous, active-low.
- i_Valid  input  1  operands valid this cycle.
- i_A  input  N  operand A, unsigned.
- i_B  input  N  operand B, unsigned.
- o_Valid  output  1  o_Sum/o_Cout hold a fresh result.
- o_Sum  output  N  approximate sum bits.
- o_Cout  output  1  carry out of the upper part (sum bit N).

Behaviour:
- Reset: on a rising edge with i_Rst_n=0, o_Valid=0, o_Sum=0, o_Cout=0. Reset overrides i_Valid on the same edge. An operation in flight is discarded.
- Combinational datapath:
  - Lower part, bits [K-1:0]: s[j] = A[j] | B[j].
  - Carry into upper part: c_K = A[K-1] & B[K-1]; c_K = 0 when K=0.
  - Upper part, bits [N-1:K]: exact ripple-carry add of A[N-1:K] + B[N-1:K] + c_K. Carry out goes to cout.
- Degenerate values of K:
  - K=0: exact N-bit adder.
  - K=N: all sum bits are ORs; cout = A[N-1] & B[N-1].
- Timing:
  - On a rising edge with i_Rst_n=1 and i_Valid=1: register {cout, s}; o_Valid=1 the next cycle. Latency is exactly 1 cycle.
  - i_Valid=0: o_Valid=0 next cycle; o_Sum/o_Cout hold their last values.
  - Back-to-back i_Valid gives one result per cycle. There is no backpressure.
- Error property: the result is never larger than the exact sum + 2^K. Error is confined to the low K bits plus the injected carry.
- No X propagation from unused ports. All outputs are driven from flops.

Optional Feature:
- Macro LOA_ERRDIST_EN.
- Defined:
  - Adds output o_ErrDist, width N+1.
  - It is registered in the same flop stage as o_Sum and equals |(A+B) - {cout,s}|, where A+B is the exact unsigned sum.
  - Reset value is 0; it holds when i_Valid=0.
- Undefined: port and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package loa_pkg:
  - default N and K constants;
  - function computing the exact reference sum width (N+1) for benches.
- Natural sub-module: loa_full_adder (1-bit a, b, cin -> s, cout). It is instantiated N-K times in a generate loop for the upper ripple chain.
- OR lane, carry generation and output register stay in loa_adder.

Test Plan (N=4, K=2):
- Reset: i_Rst_n=0 for 2 cycles while i_Valid=1, A=1111, B=1111 -> o_Valid=0, o_Sum=0000, o_Cout=0. First result appears one cycle after release.
- A=0101, B=1010, valid -> next cycle o_Sum=1111, o_Cout=0. This matches the exact result; ErrDist=0.
- A=0011, B=0001 -> o_Sum=0011, o_Cout=0 (exact 00100); ErrDist=1.
- A=0010, B=0010 -> injected carry: o_Sum=0110, o_Cout=0 (exact 00100); ErrDist=2.
- A=1111, B=1111 -> o_Sum=1111, o_Cout=1 (exact 11110); ErrDist=1. Then i_Valid=0 for 3 cycles -> outputs hold, o_Valid=0.
- Exhaustive sweep of all 256 operand pairs, back-to-back valid -> every result matches the golden LOA model one cycle later, and every ErrDist <= 4.
